// File: rtl/wc_pkg.sv
// wc_pkg: constants, feeder FSM states and tile packing shared by the wc core.
package wc_pkg;
    localparam int WC_W = 10;
    localparam int WC_TILE = 5;
    localparam int WC_STRIDE = 3;
    localparam int WC_OVL = 2;
    typedef enum logic [1:0] {FILL, PAD, FULL} wc_state_e;
    // Element 0 (oldest sample) sits in the most significant field.
    typedef logic [0:WC_TILE-1][WC_W-1:0] wc_tile_t;
    function automatic logic [WC_TILE*WC_W-1:0] wc_pack(input wc_tile_t t);
        return t;
    endfunction
    function automatic wc_tile_t wc_unpack(input logic [WC_TILE*WC_W-1:0] d);
        return d;
    endfunction
endpackage

// File: rtl/wc_tile_feeder_if.sv
// wc_tile_feeder_if: serial sample stream in, held 5-sample tile out.
interface wc_tile_feeder_if import wc_pkg::*; #(parameter int W = WC_W);
    logic [W-1:0] s_data;
    logic s_valid;
    logic s_last;
    logic s_ready;
    logic [WC_TILE*W-1:0] D;
    logic d_valid;
    logic d_first;
    logic d_row_end;
    logic [2:0] d_nreal;
    modport master (output s_data, s_valid, s_last, input s_ready, D, d_valid, d_first, d_row_end, d_nreal);
    modport slave (input s_data, s_valid, s_last, output s_ready, D, d_valid, d_first, d_row_end, d_nreal);
endinterface

// File: rtl/wc_tile_feeder.sv
// wc_tile_feeder: builds overlapping 5-sample tiles (stride 3) from a sample stream,
// zero-pads the tail of each row and holds every tile on D for HOLD cycles.
module wc_tile_feeder import wc_pkg::*; #(
    parameter int W = WC_W,
    parameter int HOLD = 6
) (
    input logic clk,
    input logic rst,
    wc_tile_feeder_if.slave bus
);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    logic [W-1:0] sbuf [WC_TILE];
    logic [2:0] cnt;
    logic [2:0] nreal;
    logic pad;
    logic row_end;
    logic accept;
    logic launch;
    logic out_free;
    logic [HW-1:0] hold_cnt;
    wc_state_e state;
    always_comb
        state = (cnt == 3'(WC_TILE)) ? FULL : pad ? PAD : FILL;
    assign bus.s_ready = (state == FILL);
    assign accept = bus.s_valid && bus.s_ready;
    assign out_free = !bus.d_valid || (hold_cnt == '0);
    assign launch = (state == FULL) && out_free;
    // A full buffer never accepts, so launch and accept are mutually exclusive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WC_TILE; i++) sbuf[i] <= '0;
            cnt <= '0;
            pad <= 1'b0;
            row_end <= 1'b0;
            nreal <= '0;
        end else if (launch) begin
            if (row_end) begin
                cnt <= '0;
                pad <= 1'b0;
                row_end <= 1'b0;
            end else begin
                for (int i = 0; i < WC_OVL; i++) sbuf[i] <= sbuf[i+WC_STRIDE];
                cnt <= 3'(WC_OVL);
            end
        end else if (accept) begin
            sbuf[cnt] <= bus.s_data;
            cnt <= cnt + 3'd1;
            if (bus.s_last) begin
                row_end <= 1'b1;
                nreal <= cnt + 3'd1;
                pad <= (cnt != 3'(WC_TILE-1));
            end
        end else if (state == PAD) begin
            sbuf[cnt] <= '0;
            cnt <= cnt + 3'd1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.D <= '0;
            bus.d_valid <= 1'b0;
            bus.d_first <= 1'b0;
            bus.d_row_end <= 1'b0;
            bus.d_nreal <= '0;
            hold_cnt <= '0;
        end else begin
            bus.d_first <= launch;
            if (launch) begin
                bus.D <= {sbuf[0], sbuf[1], sbuf[2], sbuf[3], sbuf[4]};
                bus.d_valid <= 1'b1;
                bus.d_row_end <= row_end;
                bus.d_nreal <= row_end ? nreal : 3'(WC_TILE);
                hold_cnt <= HW'(HOLD - 1);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end else begin
                bus.d_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wc_tile_feeder.sv
// tb_wc_tile_feeder: rows of samples checked against a row-level tiling model,
// on a HOLD=6 feeder and a HOLD=10 feeder selected by sel.
module tb_wc_tile_feeder;
    import wc_pkg::*;
    typedef struct packed {logic [49:0] d; logic re; logic [2:0] nr;} tile_t;
    logic clk = 0;
    logic rst = 0;
    logic sel = 0;
    logic [9:0] s_data = 0;
    logic s_valid = 0;
    logic s_last = 0;
    logic s_ready;
    logic [49:0] D;
    logic d_valid, d_first, d_row_end;
    logic [2:0] d_nreal;
    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    int hold = 6;
    tile_t got_q[$];
    tile_t exp_q[$];
    int first_cyc[$];
    logic [9:0] row[$];
    wc_tile_feeder_if #(.W(10)) bus6 ();
    wc_tile_feeder_if #(.W(10)) bus10 ();
    wc_tile_feeder #(.W(10), .HOLD(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));
    wc_tile_feeder #(.W(10), .HOLD(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10.slave));
    assign bus6.s_data = s_data;
    assign bus6.s_valid = s_valid && !sel;
    assign bus6.s_last = s_last;
    assign bus10.s_data = s_data;
    assign bus10.s_valid = s_valid && sel;
    assign bus10.s_last = s_last;
    assign s_ready = sel ? bus10.s_ready : bus6.s_ready;
    assign D = sel ? bus10.D : bus6.D;
    assign d_valid = sel ? bus10.d_valid : bus6.d_valid;
    assign d_first = sel ? bus10.d_first : bus6.d_first;
    assign d_row_end = sel ? bus10.d_row_end : bus6.d_row_end;
    assign d_nreal = sel ? bus10.d_nreal : bus6.d_nreal;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (d_first) begin
            got_q.push_back({D, d_row_end, d_nreal});
            first_cyc.push_back(cyc);
        end
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
        first_cyc.delete();
    endtask

    // Row model: tile k covers samples 3k..3k+4, zero-filled past the row end.
    task automatic model_row();
        int n, k;
        wc_tile_t t;
        tile_t e;
        n = row.size();
        k = 0;
        while (1) begin
            for (int j = 0; j < 5; j++)
                if (3*k + j < n) t[j] = row[3*k+j];
                else t[j] = 10'd0;
            e.d = wc_pack(t);
            e.re = (3*k + 5 >= n);
            e.nr = (n - 3*k >= 5) ? 3'd5 : 3'(n - 3*k);
            exp_q.push_back(e);
            if (e.re) break;
            k++;
        end
    endtask

    task automatic push(input logic [9:0] v, input logic l);
        logic acc;
        s_data = v;
        s_last = l;
        s_valid = 1;
        acc = 0;
        for (int t = 0; t < 200 && !acc; t++) begin
            acc = s_ready;
            @(negedge clk);
        end
        s_valid = 0;
        s_last = 0;
        if (!acc) begin
            ncmp++;
            nerr++;
            $display("FAIL push_timeout: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic feed_row(input int gap);
        for (int i = 0; i < row.size(); i++) begin
            if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
            push(row[i], i == row.size() - 1);
        end
    endtask

    task automatic check_tiles(input string name, input bit exact);
        int t;
        int n;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (hold + 8) @(negedge clk);
        ncmp++;
        if (got_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL %s_count: got %0d tiles required %0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            ncmp++;
            if (got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL %s_tile%0d: D=%h row_end=%b nreal=%0d required D=%h row_end=%b nreal=%0d",
                         name, i, got_q[i].d, got_q[i].re, got_q[i].nr, exp_q[i].d, exp_q[i].re, exp_q[i].nr);
            end
        end
        for (int i = 1; i < first_cyc.size(); i++) begin
            ncmp++;
            if (exact ? (first_cyc[i] - first_cyc[i-1] != hold) : (first_cyc[i] - first_cyc[i-1] < hold)) begin
                nerr++;
                $display("FAIL %s_spacing%0d: d_first gap %0d required %s%0d", name, i,
                         first_cyc[i] - first_cyc[i-1], exact ? "" : ">=", hold);
            end
        end
        clear_q();
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            ncmp += 6;
            if (D !== 50'd0) begin nerr++; $display("FAIL reset_D sel=%0d: %h required 0", s, D); end
            if (d_valid !== 1'b0) begin nerr++; $display("FAIL reset_d_valid sel=%0d: %b required 0", s, d_valid); end
            if (d_first !== 1'b0) begin nerr++; $display("FAIL reset_d_first sel=%0d: %b required 0", s, d_first); end
            if (d_row_end !== 1'b0) begin nerr++; $display("FAIL reset_d_row_end sel=%0d: %b required 0", s, d_row_end); end
            if (d_nreal !== 3'd0) begin nerr++; $display("FAIL reset_d_nreal sel=%0d: %0d required 0", s, d_nreal); end
            if (s_ready !== 1'b1) begin nerr++; $display("FAIL reset_s_ready sel=%0d: %b required 1", s, s_ready); end
        end
        sel = 0;
        @(negedge clk);
    endtask

    task automatic test_single_row();
        logic [49:0] want;
        int nv;
        want = {10'h002, 10'h3F6, 10'h003, 10'h004, 10'h3F3};
        clear_q();
        row = '{10'h002, 10'h3F6, 10'h003, 10'h004, 10'h3F3};
        feed_row(0);
        ncmp++;
        if (d_first !== 1'b0) begin nerr++; $display("FAIL single_early: d_first=%b required 0", d_first); end
        @(negedge clk);
        ncmp += 4;
        if (d_first !== 1'b1) begin nerr++; $display("FAIL single_latency: d_first=%b required 1", d_first); end
        if (D !== want) begin nerr++; $display("FAIL single_D: %h required %h", D, want); end
        if (d_row_end !== 1'b1) begin nerr++; $display("FAIL single_row_end: %b required 1", d_row_end); end
        if (d_nreal !== 3'd5) begin nerr++; $display("FAIL single_nreal: %0d required 5", d_nreal); end
        nv = 0;
        while (d_valid && nv < 50) begin
            nv++;
            @(negedge clk);
        end
        ncmp += 2;
        if (nv != 6) begin nerr++; $display("FAIL single_hold: d_valid high %0d cycles required 6", nv); end
        if (D !== want) begin nerr++; $display("FAIL single_retain: D=%h required %h", D, want); end
        model_row();
        check_tiles("single", 0);
    endtask

    task automatic test_back_to_back();
        int v[8] = '{-19, -6, 3, -9, -12, 7, 1, 5};
        row.delete();
        for (int i = 0; i < 8; i++) row.push_back(10'(v[i]));
        feed_row(0);
        model_row();
        check_tiles("b2b", 1);
    endtask

    task automatic test_pad();
        row.delete();
        for (int i = 1; i <= 5; i++) push(10'(i), 0);
        push(10'd6, 1);
        for (int i = 0; i < 2; i++) begin
            ncmp++;
            if (s_ready !== 1'b0) begin nerr++; $display("FAIL pad_ready%0d: s_ready=%b required 0", i, s_ready); end
            @(negedge clk);
        end
        for (int i = 1; i <= 6; i++) row.push_back(10'(i));
        model_row();
        check_tiles("pad", 0);
    endtask

    task automatic test_single_sample();
        row = '{10'd7};
        feed_row(0);
        model_row();
        row.delete();
        for (int i = 0; i < 5; i++) row.push_back(10'($urandom));
        feed_row(0);
        model_row();
        check_tiles("one", 0);
    endtask

    task automatic test_random(input int rows, input int minlen, input int gap, input bit exact, input string name);
        for (int r = 0; r < rows; r++) begin
            row.delete();
            for (int i = $urandom_range(minlen, 14); i > 0; i--) row.push_back(10'($urandom));
            feed_row(gap);
            model_row();
        end
        check_tiles(name, exact);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) push(10'($urandom), 0);
        ncmp++;
        if (d_valid !== 1'b1) begin nerr++; $display("FAIL mid_pre: d_valid=%b required 1", d_valid); end
        #2 rst = 0;
        #1;
        ncmp += 6;
        if (D !== 50'd0) begin nerr++; $display("FAIL mid_D: %h required 0", D); end
        if (d_valid !== 1'b0) begin nerr++; $display("FAIL mid_d_valid: %b required 0", d_valid); end
        if (d_first !== 1'b0) begin nerr++; $display("FAIL mid_d_first: %b required 0", d_first); end
        if (d_row_end !== 1'b0) begin nerr++; $display("FAIL mid_d_row_end: %b required 0", d_row_end); end
        if (d_nreal !== 3'd0) begin nerr++; $display("FAIL mid_d_nreal: %0d required 0", d_nreal); end
        if (s_ready !== 1'b1) begin nerr++; $display("FAIL mid_s_ready: %b required 1", s_ready); end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        clear_q();
        row.delete();
        for (int i = 0; i < 5; i++) row.push_back(10'($urandom));
        feed_row(0);
        model_row();
        check_tiles("mid", 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1;
        test_reset();
        test_single_row();
        test_back_to_back();
        test_pad();
        test_single_sample();
        test_random(8, 1, 3, 0, "rand6");
        sel = 1;
        hold = 10;
        @(negedge clk);
        test_random(6, 1, 0, 1, "stall10");
        test_random(4, 1, 4, 0, "gap10");
        sel = 0;
        hold = 6;
        @(negedge clk);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
